// File: rtl/cpu32_alu_pkg.sv
// Shared types and helpers for the cpu32 ALU datapath blocks.
// Holds the flag bundle and the saturation constant used by addsub_pipe.
package cpu32_alu_pkg;

    localparam int ADDSUB_MAX_STAGES = 8;
    localparam int ADDSUB_MAX_WIDTH  = 256;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
    } alu_flags_t;

    // Signed limit of a width-bit word: msb=1 gives the most negative value, msb=0 the most positive.
    function automatic logic [ADDSUB_MAX_WIDTH-1:0] sat_value(input logic msb, input int width);
        logic [ADDSUB_MAX_WIDTH-1:0] ones;
        ones = {ADDSUB_MAX_WIDTH{1'b1}} >> (ADDSUB_MAX_WIDTH - width);
        return msb ? (ones ^ (ones >> 1)) : (ones >> 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CW-bit slice of the pipelined carry chain: plain adder with carry in/out.
// Exposes the operand and sum MSBs so the last slice can derive signed overflow.
module addsub_slice #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          a_msb,
    output logic          b_msb,
    output logic          sum_msb
);

    logic [CW:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum     = total[CW-1:0];
    assign cout    = total[CW];
    assign a_msb   = a[CW-1];
    assign b_msb   = b[CW-1];
    assign sum_msb = total[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: STAGES carry-chain slices behind a valid/ready handshake.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN.
module addsub_pipe
    import cpu32_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
`ifdef ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // word_q[s]: finished sum bits below the next slice, untouched A bits above it.
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] word_q, word_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
`ifdef ADDSUB_SAT_EN
    logic [STAGES-1:0]            sat_q, sat_d;
`endif
    alu_flags_t                   flags_q, flags_d;

    logic                         adv;
    logic                         ovf;
    logic [WIDTH-1:0]             b_eff;
    logic [STAGES-1:0][CW-1:0]    sl_a, sl_b, sl_sum;
    logic [STAGES-1:0]            sl_cin, sl_cout, sl_a_msb, sl_b_msb, sl_sum_msb;

    assign adv   = ~vld_q[LAST] | out_ready;
    assign b_eff = in_sub ? ~in_b : in_b;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        if (s == 0) begin : g_first
            assign sl_a[s]   = in_a[CW-1:0];
            assign sl_b[s]   = b_eff[CW-1:0];
            assign sl_cin[s] = in_sub;
        end else begin : g_next
            assign sl_a[s]   = word_q[s-1][s*CW +: CW];
            assign sl_b[s]   = b_q[s-1][s*CW +: CW];
            assign sl_cin[s] = carry_q[s-1];
        end

        addsub_slice #(.CW(CW)) u_slice (
            .a       (sl_a[s]),
            .b       (sl_b[s]),
            .cin     (sl_cin[s]),
            .sum     (sl_sum[s]),
            .cout    (sl_cout[s]),
            .a_msb   (sl_a_msb[s]),
            .b_msb   (sl_b_msb[s]),
            .sum_msb (sl_sum_msb[s])
        );
    end

    always_comb begin
        vld_d   = vld_q;
        carry_d = carry_q;
        word_d  = word_q;
        b_d     = b_q;
        tag_d   = tag_q;
`ifdef ADDSUB_SAT_EN
        sat_d   = sat_q;
`endif
        flags_d = flags_q;
        ovf     = 1'b0;
        if (adv) begin
            vld_d[0]  = in_valid;
            word_d[0] = in_a;
            b_d[0]    = b_eff;
            tag_d[0]  = in_tag;
`ifdef ADDSUB_SAT_EN
            sat_d[0]  = in_sat;
`endif
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                word_d[s] = word_q[s-1];
                b_d[s]    = b_q[s-1];
                tag_d[s]  = tag_q[s-1];
`ifdef ADDSUB_SAT_EN
                sat_d[s]  = sat_q[s-1];
`endif
            end
            for (int s = 0; s < STAGES; s++) begin
                word_d[s][s*CW +: CW] = sl_sum[s];
                carry_d[s]            = sl_cout[s];
            end

            // Final stage: overflow from the top slice, then optional clamp, then flags on the result.
            ovf = (sl_a_msb[LAST] == sl_b_msb[LAST]) & (sl_sum_msb[LAST] != sl_a_msb[LAST]);
`ifdef ADDSUB_SAT_EN
            if (sat_d[LAST] && ovf) begin
                word_d[LAST] = WIDTH'(sat_value(sl_a_msb[LAST], WIDTH));
            end
`endif
            flags_d.carry = carry_d[LAST];
            flags_d.ovf   = ovf;
            flags_d.zero  = (word_d[LAST] == '0);
            flags_d.neg   = word_d[LAST][WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            word_q  <= '0;
            b_q     <= '0;
            tag_q   <= '0;
`ifdef ADDSUB_SAT_EN
            sat_q   <= '0;
`endif
            flags_q <= '0;
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            word_q  <= word_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
`ifdef ADDSUB_SAT_EN
            sat_q   <= sat_d;
`endif
            flags_q <= flags_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign out_sum   = word_q[LAST];
    assign out_carry = flags_q.carry;
    assign out_ovf   = flags_q.ovf;
    assign out_zero  = flags_q.zero;
    assign out_neg   = flags_q.neg;
    assign out_tag   = tag_q[LAST];

endmodule
